// File: rtl/sobel_window_gen.sv
// Raster-to-window front end for the Sobel stage.
// Two line buffers plus shift regs give interior 3x3 windows.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       pix_in,
    input  logic             pix_sof,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [7:0]       p00,
    output logic [7:0]       p01,
    output logic [7:0]       p02,
    output logic [7:0]       p10,
    output logic [7:0]       p11,
    output logic [7:0]       p12,
    output logic [7:0]       p20,
    output logic [7:0]       p21,
    output logic [7:0]       p22,
    output logic [COL_W-1:0] win_x,
    output logic [ROW_W-1:0] win_y,
    output logic             win_valid,
    input  logic             win_ready,
    output logic             frame_done,
    output logic             sof_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    localparam logic [COL_W-1:0] C_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] R_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] C_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] C_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] R_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] R_TWO  = ROW_W'(2);

    state_t           state;
    state_t           state_nx;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] cur_c;
    logic [ROW_W-1:0] cur_r;
    logic [7:0]       lb0 [IMG_WIDTH];
    logic [7:0]       lb1 [IMG_WIDTH];
    logic [7:0]       top;
    logic [7:0]       mid;
    logic [7:0]       ta, tb, ma, mb, ba, bb;
    logic             accept;
    logic             take;
    logic             gate;
    logic             col_last;
    logic             row_last;

    assign pix_ready = !reset && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign take      = accept && (pix_sof || state == ACTIVE);
    assign cur_c     = pix_sof ? '0 : col;
    assign cur_r     = pix_sof ? '0 : row;
    assign top       = lb1[cur_c];
    assign mid       = lb0[cur_c];
    assign col_last  = cur_c == C_LAST;
    assign row_last  = cur_r == R_LAST;
    assign gate      = cur_r >= R_TWO && cur_c >= C_TWO;

    // Frame state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Frame sequencing; DONE treats new pixels like IDLE.
    always_comb begin
        state_nx   = state;
        frame_done = 1'b0;
        unique case (state)
            IDLE:   if (take) state_nx = ACTIVE;
            ACTIVE: begin
                if (take && col_last && row_last)
                    state_nx = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nx   = take ? ACTIVE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Raster position of the next expected pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (take) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : cur_r + R_ONE;
            end else begin
                col <= cur_c + C_ONE;
                row <= cur_r;
            end
        end
    end

    // Line buffers: new pixel in lb0, old lb0 cascades to lb1.
    always_ff @(posedge clk) begin
        if (take) begin
            lb0[cur_c] <= pix_in;
            lb1[cur_c] <= mid;
        end
    end

    // Two previous columns per row; flushed at row start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {ta, tb, ma, mb, ba, bb} <= '0;
        end else if (take) begin
            if (cur_c == '0) begin
                {ta, ma, ba} <= '0;
            end else begin
                ta <= tb;
                ma <= mb;
                ba <= bb;
            end
            tb <= top;
            mb <= mid;
            bb <= pix_in;
        end
    end

    // Window output register with hold under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {p00, p01, p02} <= '0;
            {p10, p11, p12} <= '0;
            {p20, p21, p22} <= '0;
            win_x     <= '0;
            win_y     <= '0;
            win_valid <= 1'b0;
        end else if (take && gate) begin
            {p00, p01, p02} <= {ta, tb, top};
            {p10, p11, p12} <= {ma, mb, mid};
            {p20, p21, p22} <= {ba, bb, pix_in};
            win_x     <= cur_c - C_ONE;
            win_y     <= cur_r - R_ONE;
            win_valid <= 1'b1;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

    // Resync pulse for a start-of-frame inside a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sof_err <= 1'b0;
        else       sof_err <= take && pix_sof && state == ACTIVE;
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 frame.
// Table-driven first frame plus scoreboard sequences.
module tb_sobel_window_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    pix_in = '0;
    logic          pix_sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [7:0]    p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic [CW-1:0] win_x;
    logic [RW-1:0] win_y;
    logic          win_valid;
    logic          win_ready = 1'b1;
    logic          frame_done;
    logic          sof_err;
    logic [71:0]   cur_p;

    sobel_window_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_in    (pix_in),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .p00       (p00),
        .p01       (p01),
        .p02       (p02),
        .p10       (p10),
        .p11       (p11),
        .p12       (p12),
        .p20       (p20),
        .p21       (p21),
        .p22       (p22),
        .win_x     (win_x),
        .win_y     (win_y),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .frame_done(frame_done),
        .sof_err   (sof_err)
    );

    always #5 clk = ~clk;

    assign cur_p = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

    typedef struct packed {
        logic [71:0] p;
        logic [7:0]  x;
        logic [7:0]  y;
    } win_t;

    typedef struct {
        logic [7:0]  pix;
        bit          sof;
        bit          ev;
        logic [71:0] ep;
        logic [7:0]  ex;
        logic [7:0]  ey;
    } vec_t;

    win_t       got[$];
    win_t       exp_q[$];
    win_t       mw;
    int         tests = 0;
    int         fails = 0;
    int         fd_cnt = 0;
    int         se_cnt = 0;
    bit         rnd_ready = 1'b0;
    logic [7:0] img [H][W];
    vec_t       tbl [W*H];

    // Capture every window handed downstream, plus pulses.
    always @(negedge clk) begin
        if (win_valid && win_ready) begin
            mw.p = cur_p;
            mw.x = 8'(win_x);
            mw.y = 8'(win_y);
            got.push_back(mw);
        end
        if (frame_done) fd_cnt++;
        if (sof_err) se_cnt++;
    end

    // Random downstream backpressure when enabled.
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            win_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [71:0] act,
                       input logic [71:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic win_t mk(input int r, input int c);
        win_t w;
        w.p = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
               img[r-1][c-2], img[r-1][c-1], img[r-1][c],
               img[r][c-2], img[r][c-1], img[r][c]};
        w.x = 8'(c - 1);
        w.y = 8'(r - 1);
        return w;
    endfunction

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'(r * 16 + c);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'($urandom);
    endtask

    task automatic add_exp();
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                exp_q.push_back(mk(r, c));
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept.
    task automatic push(input logic [7:0] v, input bit sof);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        pix_in = v;
        pix_sof = sof;
        pix_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = pix_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: got no accept expected accept");
        end
        pix_valid = 1'b0;
        pix_sof = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (gaps && $urandom_range(0, 1) == 1) begin
                    @(posedge clk);
                    #1;
                end
                push(img[r][c], r == 0 && c == 0);
            end
    endtask

    task automatic drain();
        int n;
        n = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        while (win_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_idle", 72'(win_valid), 72'(0));
    endtask

    task automatic compare(input string nm);
        chk({nm, "_count"}, 72'(got.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s_pix%0d", nm, i), got[i].p, exp_q[i].p);
            chk($sformatf("%s_xy%0d", nm, i),
                72'({got[i].x, got[i].y}),
                72'({exp_q[i].x, exp_q[i].y}));
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic clear_counts();
        got.delete();
        exp_q.delete();
        fd_cnt = 0;
        se_cnt = 0;
    endtask

    initial begin
        // Vector table for the plain 5x4 ramp frame.
        fill_ramp();
        for (int i = 0; i < W * H; i++) begin
            int r;
            int c;
            win_t w;
            r = i / W;
            c = i % W;
            tbl[i].pix = 8'(r * 16 + c);
            tbl[i].sof = (i == 0);
            tbl[i].ev = (r >= 2 && c >= 2);
            tbl[i].ep = '0;
            tbl[i].ex = '0;
            tbl[i].ey = '0;
            if (tbl[i].ev) begin
                w = mk(r, c);
                tbl[i].ep = w.p;
                tbl[i].ex = w.x;
                tbl[i].ey = w.y;
            end
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pix_ready", 72'(pix_ready), 72'(0));
        chk("rst_win_valid", 72'(win_valid), 72'(0));
        chk("rst_p", cur_p, 72'(0));
        chk("rst_xy", 72'({win_x, win_y}), 72'(0));
        chk("rst_pulses", 72'({frame_done, sof_err}), 72'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("pix_ready_after_rst", 72'(pix_ready), 72'(1));

        // Scenario 1: table-driven, checked every accept.
        clear_counts();
        for (int i = 0; i < W * H; i++) begin
            push(tbl[i].pix, tbl[i].sof);
            chk($sformatf("s1_valid%0d", i), 72'(win_valid),
                72'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("s1_p%0d", i), cur_p, tbl[i].ep);
                chk($sformatf("s1_xy%0d", i), 72'({8'(win_x), 8'(win_y)}),
                    72'({tbl[i].ex, tbl[i].ey}));
            end
            if (i == 12)
                chk("s1_first_const", cur_p,
                    72'h00_01_02_10_11_12_20_21_22);
        end
        chk("s1_last_p22", 72'(p22), 72'(8'h34));
        chk("s1_last_xy", 72'({8'(win_x), 8'(win_y)}), 72'(16'h0302));
        chk("s1_frame_done", 72'(frame_done), 72'(1));
        @(posedge clk);
        #1;
        chk("s1_frame_done_clr", 72'(frame_done), 72'(0));
        drain();
        chk("s1_win_total", 72'(got.size()), 72'(6));
        chk("s1_fd_cnt", 72'(fd_cnt), 72'(1));

        // Scenario 2: stall downstream after the first window.
        clear_counts();
        fill_ramp();
        add_exp();
        for (int i = 0; i <= 12; i++)
            push(img[i / W][i % W], i == 0);
        chk("s2_first_valid", 72'(win_valid), 72'(1));
        win_ready = 1'b0;
        pix_in = img[2][3];
        pix_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("s2_ready_low%0d", k), 72'(pix_ready), 72'(0));
            chk($sformatf("s2_hold%0d", k), cur_p,
                72'h00_01_02_10_11_12_20_21_22);
            chk($sformatf("s2_hold_v%0d", k), 72'(win_valid), 72'(1));
            @(posedge clk);
            #1;
        end
        win_ready = 1'b1;
        for (int i = 13; i < W * H; i++)
            push(img[i / W][i % W], 1'b0);
        drain();
        compare("s2");
        chk("s2_fd_cnt", 72'(fd_cnt), 72'(1));

        // Scenario 3: junk before the first pix_sof.
        clear_counts();
        for (int k = 0; k < 7; k++)
            push(8'(8'hA0 + k), 1'b0);
        fill_ramp();
        add_exp();
        send_frame(1'b0);
        drain();
        compare("s3");
        chk("s3_fd_cnt", 72'(fd_cnt), 72'(1));

        // Scenario 4: resync with pix_sof at (1,3).
        clear_counts();
        for (int k = 0; k < 8; k++)
            push(8'(8'hF0 + k), k == 0);
        fill_ramp();
        add_exp();
        send_frame(1'b0);
        drain();
        compare("s4");
        chk("s4_sof_err", 72'(se_cnt), 72'(1));
        chk("s4_fd_cnt", 72'(fd_cnt), 72'(1));

        // Scenario 5: async reset while a window is held.
        clear_counts();
        fill_ramp();
        for (int i = 0; i <= 13; i++)
            push(img[i / W][i % W], i == 0);
        chk("s5_pre_valid", 72'(win_valid), 72'(1));
        chk("s5_pre_p22", 72'(p22), 72'(8'h23));
        #2;
        reset = 1'b1;
        #1;
        chk("s5_valid_clr", 72'(win_valid), 72'(0));
        chk("s5_p_clr", cur_p, 72'(0));
        chk("s5_xy_clr", 72'({win_x, win_y}), 72'(0));
        chk("s5_ready_low", 72'(pix_ready), 72'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_counts();
        add_exp();
        send_frame(1'b0);
        drain();
        compare("s5");
        chk("s5_fd_cnt", 72'(fd_cnt), 72'(1));

        // Scenario 6: two random frames, gaps and backpressure.
        clear_counts();
        rnd_ready = 1'b1;
        fill_rand();
        add_exp();
        send_frame(1'b1);
        fill_rand();
        add_exp();
        send_frame(1'b1);
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        win_ready = 1'b1;
        drain();
        compare("s6");
        chk("s6_fd_cnt", 72'(fd_cnt), 72'(2));
        chk("s6_sof_err", 72'(se_cnt), 72'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
